// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the post-normalizer state type for the add/sub datapath.
package fp32_pkg;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} postnorm_state_t;

    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
    localparam logic [7:0] FP32_BIAS    = 8'd127;
    localparam int         FP32_MAN_W   = 23;
    localparam int         FP32_WORK_W  = 28;
endpackage

// File: rtl/fp32_round_rne.sv
// Combinational round-to-nearest-even of a 24-bit mantissa (hidden bit included),
// with exponent bump on mantissa carry-out and exponent overflow detection.
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [FP32_MAN_W:0] mant_i,
    input  logic                guard_i,
    input  logic                rs_i,
    input  logic [7:0]          exp_i,
    output logic [FP32_MAN_W:0] mant_o,
    output logic [7:0]          exp_o,
    output logic                overflow_o
);
    logic                  round_up;
    logic [FP32_MAN_W+1:0] mant_sum;
    logic [8:0]            exp_sum;

    always_comb begin
        round_up = guard_i & (rs_i | mant_i[0]);
        mant_sum = {1'b0, mant_i} + {{(FP32_MAN_W+1){1'b0}}, round_up};
        // An all-ones mantissa rounding up lands exactly on 2^24; renormalize by one.
        if (mant_sum[FP32_MAN_W+1]) begin
            mant_o  = mant_sum[FP32_MAN_W+1:1];
            exp_sum = {1'b0, exp_i} + 9'd1;
        end else begin
            mant_o  = mant_sum[FP32_MAN_W:0];
            exp_sum = {1'b0, exp_i};
        end
        overflow_o = (exp_sum >= {1'b0, FP32_EXP_MAX});
        exp_o      = exp_sum[7:0];
    end
endmodule

// File: rtl/fp32_addsub_postnorm.sv
// FP32 add/sub back end: iterative left-shift renormalization, RNE rounding and
// IEEE-754 packing, with valid/ready handshakes on input and output.
module fp32_addsub_postnorm
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] man_sum,
    input  logic [2:0]  grs,
    input  logic [7:0]  exponent,
    input  logic        result_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow
);
    postnorm_state_t        state_q;
    logic [FP32_WORK_W-1:0] w_q;
    logic [7:0]             e_q;
    logic                   s_q;
    logic [31:0]            result_q;
    logic                   overflow_q;

    logic [FP32_MAN_W:0]    rnd_mant;
    logic [7:0]             rnd_exp;
    logic                   rnd_ovf;
    logic [31:0]            packed_word;

    fp32_round_rne u_round (
        .mant_i     (w_q[26:3]),
        .guard_i    (w_q[2]),
        .rs_i       (w_q[1] | w_q[0]),
        .exp_i      (e_q),
        .mant_o     (rnd_mant),
        .exp_o      (rnd_exp),
        .overflow_o (rnd_ovf)
    );

    always_comb begin
        if (rnd_ovf) begin
            packed_word = {s_q, FP32_EXP_MAX, {FP32_MAN_W{1'b0}}};
        end else if (!rnd_mant[FP32_MAN_W]) begin
            packed_word = {s_q, 8'h00, rnd_mant[FP32_MAN_W-1:0]};
        end else begin
            packed_word = {s_q, rnd_exp, rnd_mant[FP32_MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            e_q        <= '0;
            s_q        <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q     <= {man_sum, grs};
                        e_q     <= exponent;
                        s_q     <= result_sign;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    // Carry folds the dropped bit into sticky so rounding still sees it.
                    if (w_q[27]) begin
                        w_q     <= {1'b0, w_q[27:2], w_q[1] | w_q[0]};
                        e_q     <= e_q + 8'd1;
                        state_q <= ROUND;
                    end else if (w_q == '0) begin
                        result_q   <= 32'h0;
                        overflow_q <= 1'b0;
                        state_q    <= OUT;
                    end else if (w_q[26] || (e_q <= 8'd1)) begin
                        state_q <= ROUND;
                    end else begin
                        w_q <= w_q << 1;
                        e_q <= e_q - 8'd1;
                    end
                end
                ROUND: begin
                    result_q   <= packed_word;
                    overflow_q <= rnd_ovf;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & rst_n;
    assign out_valid = (state_q == OUT);
    assign result    = result_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_fp32_addsub_postnorm.sv
// Directed-vector bench for the FP32 post-normalizer, checked against an arithmetic
// model of the normalize/round/pack rules with a per-cycle output monitor.
module tb_fp32_addsub_postnorm;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] man_sum;
    logic [2:0]  grs;
    logic [7:0]  exponent;
    logic        result_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen = 0;

    typedef struct {
        logic [31:0] r;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    fp32_addsub_postnorm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .man_sum     (man_sum),
        .grs         (grs),
        .exponent    (exponent),
        .result_sign (result_sign),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, expv);
        end
    endtask

    // Value-level model: treat {man_sum,grs} as an integer with 3 fraction bits below the LSB.
    function automatic void model(input logic [24:0] m, input logic [2:0] g, input logic [7:0] e,
                                  input logic s, output logic [31:0] r, output logic ovf,
                                  output int lat);
        logic [63:0] w;
        logic [63:0] mm;
        int ex;
        int sh;
        w = {39'd0, m, g};
        ex = int'(e);
        sh = 0;
        r = 32'h0;
        ovf = 1'b0;
        lat = 2;
        if (w == 64'd0) return;
        if (w >= (64'd1 << 27)) begin
            w = (w >> 1) | (w & 64'd1);
            ex = ex + 1;
        end else begin
            while (w < (64'd1 << 26) && ex > 1) begin
                w = w << 1;
                ex = ex - 1;
                sh = sh + 1;
            end
        end
        mm = w >> 3;
        if (w[2] && (w[1] || w[0] || mm[0])) mm = mm + 64'd1;
        if (mm == (64'd1 << 24)) begin
            mm = mm >> 1;
            ex = ex + 1;
        end
        lat = 3 + sh;
        if (ex >= 255) begin
            r = {s, 8'hFF, 23'h0};
            ovf = 1'b1;
        end else if (mm < (64'd1 << 23)) begin
            r = {s, 8'h00, mm[22:0]};
        end else begin
            r = {s, ex[7:0], mm[22:0]};
        end
    endfunction

    task automatic pin(input string name, input logic [24:0] m, input logic [2:0] g,
                       input logic [7:0] e, input logic s, input logic [31:0] r_exp,
                       input logic ovf_exp, input int lat_exp);
        logic [31:0] r;
        logic ovf;
        int lat;
        model(m, g, e, s, r, ovf, lat);
        chk({name, "_model_result"}, r, r_exp);
        chk({name, "_model_ovf"}, {31'd0, ovf}, {31'd0, ovf_exp});
        chk({name, "_model_lat"}, lat, lat_exp);
    endtask

    task automatic send(input logic [24:0] m, input logic [2:0] g, input logic [7:0] e,
                        input logic s);
        exp_t x;
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        man_sum = m;
        grs = g;
        exponent = e;
        result_sign = s;
        in_valid = 1'b1;
        model(m, g, e, s, x.r, x.ovf, x.lat);
        x.acc = cyc;
        q.push_back(x);
        $display("op man_sum=%h grs=%b exp=%h sign=%0d expect=%h ovf=%0d lat=%0d",
                 m, g, e, s, x.r, x.ovf, x.lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
            q.delete();
        end
    endtask

    task automatic run(input logic [24:0] m, input logic [2:0] g, input logic [7:0] e,
                       input logic s);
        send(m, g, e, s);
        wait_done();
    endtask

    // Output monitor: every cycle out_valid is high, compare against the head expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!seen) chk("latency", cyc - q[0].acc, q[0].lat);
                    seen = 1'b1;
                    chk("result", result, q[0].r);
                    chk("overflow", {31'd0, overflow}, {31'd0, q[0].ovf});
                    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual %0d required finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        man_sum = '0;
        grs = '0;
        exponent = '0;
        result_sign = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        pin("sum42", 25'h0C00000, 3'b000, 8'h81, 1'b0, 32'h40C00000, 1'b0, 3);
        pin("carry44", 25'h1000000, 3'b000, 8'h81, 1'b0, 32'h41000000, 1'b0, 3);
        pin("cancel", 25'h0400000, 3'b000, 8'h81, 1'b0, 32'h40000000, 1'b0, 4);
        pin("zero", 25'h0000000, 3'b000, 8'h81, 1'b1, 32'h00000000, 1'b0, 2);
        pin("tie_up", 25'h0800001, 3'b100, 8'h7F, 1'b0, 32'h3F800002, 1'b0, 3);
        pin("tie_even", 25'h0800000, 3'b100, 8'h7F, 1'b0, 32'h3F800000, 1'b0, 3);
        pin("ovf", 25'h1FFFFFF, 3'b000, 8'hFE, 1'b1, 32'hFF800000, 1'b1, 3);
        pin("maxshift", 25'h0000001, 3'b000, 8'h90, 1'b0, 32'h3C800000, 1'b0, 26);
        pin("denorm", 25'h0100000, 3'b000, 8'h03, 1'b0, 32'h00400000, 1'b0, 5);

        run(25'h0C00000, 3'b000, 8'h81, 1'b0);
        run(25'h1000000, 3'b000, 8'h81, 1'b0);
        run(25'h0400000, 3'b000, 8'h81, 1'b0);
        run(25'h0000000, 3'b000, 8'h81, 1'b1);
        run(25'h0800001, 3'b100, 8'h7F, 1'b0);
        run(25'h0800000, 3'b100, 8'h7F, 1'b0);
        run(25'h1FFFFFF, 3'b000, 8'hFE, 1'b1);
        run(25'h0800000, 3'b110, 8'h7F, 1'b0);
        run(25'h0800000, 3'b011, 8'h7F, 1'b0);
        run(25'h0FFFFFF, 3'b100, 8'h80, 1'b0);
        run(25'h1000001, 3'b001, 8'h81, 1'b0);
        run(25'h0100000, 3'b000, 8'h03, 1'b0);
        run(25'h0400000, 3'b000, 8'h01, 1'b0);
        run(25'h0000001, 3'b000, 8'h90, 1'b0);
        run(25'h0C00000, 3'b000, 8'h81, 1'b1);

        // Back-pressure: hold the result for 5 cycles while in_valid is asserted.
        out_ready = 1'b0;
        send(25'h0C00000, 3'b000, 8'h81, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) begin
            man_sum = 25'h1000000;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Reset while shifting in NORM discards the operation.
        send(25'h0000100, 3'b000, 8'h90, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
        run(25'h0800001, 3'b100, 8'h7F, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_addsub_postnorm.md
# fp32_addsub_postnorm

Back end of the FP32 add/sub datapath, driven by the operand alignment/normalization stage. Accepts the raw 25-bit mantissa sum/difference, the larger-operand biased exponent, guard/round/sticky bits and the result sign. Renormalizes iteratively, with one left shift per cycle. Rounds round-to-nearest-even and packs an IEEE-754 single. A valid/ready handshake sits on both sides.

## Interface
- No parameters; widths fixed by FP32 (constants in `fp32_pkg`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: block idle, can accept.
- `man_sum` in 25: bit 24 is the carry; bit 23 is the hidden-bit position.
- `grs` in 3: guard, round, sticky bits from alignment.
- `exponent` in 8: biased exponent of the larger operand.
- `result_sign` in 1: sign of the result.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer accepts result.
- `result` out 32: packed FP32.
- `overflow` out 1: result saturated to ±Inf; valid with `out_valid`.

## Operation
- Working register `w[27:0] = {man_sum, grs}` and `e[7:0]`, `s`. Layout: `w[27]` carry, `w[26]` hidden bit, `w[26:3]` mantissa, `w[2]` G, `w[1]|w[0]` RS.
- **IDLE:**
  - `in_ready = 1`.
  - On `in_valid & in_ready`, load `w`, `e`, `s`, then go to NORM.
- **NORM** (one action per cycle, checked in this priority order):
  1. `w[27]=1`: `w <= {0, w[27:2], w[1]|w[0]}`, `e <= e+1`, go to ROUND.
  2. `w==0`: go to OUT with `result = 32'h0` (exact cancellation gives +0).
  3. `w[26]=1`: go to ROUND.
  4. `e<=1`: stop shifting (denormal), go to ROUND.
  5. Otherwise: `w <= w<<1`, `e <= e-1`, stay in NORM.
- **ROUND:**
  - Round up when `G & (RS | m[0])`.
  - If the rounded mantissa carries out to 2^24, shift right 1 and increment `e`.
  - If `e>=255`: `result = {s, 8'hFF, 23'h0}`, `overflow = 1`.
  - Else if the hidden bit is 0 (denormal): pack exponent `8'h00`.
  - Else: `result = {s, e, m[22:0]}`.
  - Go to OUT.
- **OUT:**
  - `out_valid = 1`; `result` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- Input exponent 0 with non-zero mantissa: treated by the NORM `e<=1` rule, so no shift occurs.

## Timing
- Reset values:
  - state IDLE, `out_valid 0`, `result 32'h0`, `overflow 0`.
  - `in_ready = (state==IDLE) & rst_n`, so it is 0 during reset and 1 on the first cycle after reset.
- Latency, counted from the accept edge (cycle 0):
  - Normalized or carry input: NORM at cycle 1, ROUND at cycle 2, `out_valid` at cycle 3.
  - Each left shift adds 1 cycle; the maximum is 23 shifts, giving 26 cycles.
  - Zero input: `out_valid` at cycle 2.
- Throughput: one operation in flight. `in_ready` stays low from the accept edge until the OUT handshake completes.
- Back-to-back: on an OUT handshake the block returns to IDLE. The next accept happens no earlier than the following cycle.
- Reset mid-operation: `rst_n` low in any state. At the next edge the block is in IDLE, `out_valid` is 0, and the partial result is discarded.
- `out_ready` asserted before `out_valid` has no effect.
- `in_valid` during non-IDLE states is ignored and not queued.

## Structure
- `fp32_pkg`:
  - `typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} postnorm_state_t`.
  - Constants `FP32_EXP_MAX = 8'hFF`, `FP32_BIAS = 8'd127`, `FP32_MAN_W = 23`, `FP32_WORK_W = 28`.
- Sub-module `fp32_round_rne` (combinational):
  - Inputs: mantissa[23:0], G, RS, e.
  - Outputs: rounded mantissa, adjusted exponent, overflow.
  - Reused by the future FP32 multiplier.

## Test plan
- Sum 4.0+2.0: `man_sum=25'h0C00000`, `grs=0`, `exponent=8'h81`, sign 0 -> `result=32'h40C00000`, `out_valid` at cycle 3, `overflow 0`.
- Carry 4.0+4.0: `man_sum=25'h1000000`, `exponent=8'h81` -> `32'h41000000` at cycle 3.
- Cancellation 4.0-2.0: `man_sum=25'h0400000`, `exponent=8'h81` -> one shift, `32'h40000000` at cycle 4. A full cancel (`man_sum=0`, sign 1) gives `32'h00000000` at cycle 2.
- Ties to even:
  - `man_sum=25'h0800001`, `grs=3'b100`, `exponent=8'h7F` -> `32'h3F800002`.
  - `man_sum=25'h0800000`, same `grs` and exponent -> `32'h3F800000`.
- Overflow: `man_sum=25'h1FFFFFF`, `grs=0`, `exponent=8'hFE`, sign 1 -> `32'hFF800000`, `overflow=1`.
- Handshake and reset:
  - Hold `out_ready=0` for 5 cycles: `result` stays stable and `in_ready` stays 0.
  - Pull `rst_n=0` while in NORM: `out_valid=0` next cycle, then `in_ready=1` after `rst_n` returns high.
